// File: rtl/ps_width_multiplier.sv
// PacketStream width widener: packs COUNT narrow words into one wide word, flagging short
// packet tails with o_mty. Optional feature macro: PS_WIDTH_MULTIPLIER_ZERO_FILL_EN.
module ps_width_multiplier #(
   parameter int WIDTH = 4,
   parameter int COUNT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           i_dat,
   input  logic                       i_val,
   input  logic                       i_eop,
   output logic                       i_rdy,
   output logic [COUNT*WIDTH-1:0]     o_dat,
   output logic [$clog2(COUNT)-1:0]   o_mty,
   output logic                       o_val,
   output logic                       o_eop,
   input  logic                       o_rdy
);

   localparam int CW = $clog2(COUNT);
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   logic [COUNT*WIDTH-1:0] dat_q, dat_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          mty_q, mty_d;
   logic                   val_q, val_d;
   logic                   eop_q, eop_d;
   logic                   accept, consume, complete;

   assign i_rdy    = ~val_q | o_rdy;
   assign accept   = i_val & i_rdy;
   assign consume  = val_q & o_rdy;
   assign complete = accept & ((cnt_q == LAST) | i_eop);

   // The assembly register doubles as the output register: it is only written
   // when the previous word is absent or being consumed in the same cycle.
   always_comb begin
      dat_d = dat_q;
      for (int s = 0; s < COUNT; s++) begin
         if (accept && (cnt_q == CW'(s))) begin
            dat_d[s*WIDTH +: WIDTH] = i_dat;
`ifdef PS_WIDTH_MULTIPLIER_ZERO_FILL_EN
         end else if (accept && i_eop && (CW'(s) > cnt_q)) begin
            dat_d[s*WIDTH +: WIDTH] = '0;
`endif
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      val_d = val_q;
      eop_d = eop_q;
      mty_d = mty_q;
      if (accept) begin
         cnt_d = complete ? '0 : cnt_q + 1'b1;
      end
      if (complete) begin
         val_d = 1'b1;
         eop_d = i_eop;
         mty_d = i_eop ? (LAST - cnt_q) : '0;
      end else if (consume) begin
         val_d = 1'b0;
         eop_d = 1'b0;
         mty_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_q <= '0;
         cnt_q <= '0;
         mty_q <= '0;
         val_q <= 1'b0;
         eop_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         cnt_q <= cnt_d;
         mty_q <= mty_d;
         val_q <= val_d;
         eop_q <= eop_d;
      end
   end

   assign o_dat = dat_q;
   assign o_mty = mty_q;
   assign o_val = val_q;
   assign o_eop = eop_q;

endmodule

// File: tb/tb_ps_width_multiplier.sv
// Self-checking bench for ps_width_multiplier: vector table plus scoreboard on a
// WIDTH=8/COUNT=4 instance, and a streaming run on a WIDTH=4/COUNT=3 instance.
module tb_ps_width_multiplier;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  i_dat;
   logic        i_val, i_eop, i_rdy;
   logic [31:0] o_dat;
   logic [1:0]  o_mty;
   logic        o_val, o_eop, o_rdy;

   logic [3:0]  i_dat2;
   logic        i_val2, i_eop2, i_rdy2;
   logic [11:0] o_dat2;
   logic [1:0]  o_mty2;
   logic        o_val2, o_eop2, o_rdy2;

   int total = 0;
   int bad   = 0;
   int n_out2 = 0;
   int cyc = 0;
   int last_cyc = 0;

   always #5 clk = ~clk;

   ps_width_multiplier #(.WIDTH(8), .COUNT(4)) dut (
      .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
      .o_dat(o_dat), .o_mty(o_mty), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
   );

   ps_width_multiplier #(.WIDTH(4), .COUNT(3)) dut2 (
      .clk(clk), .reset(reset), .i_dat(i_dat2), .i_val(i_val2), .i_eop(i_eop2), .i_rdy(i_rdy2),
      .o_dat(o_dat2), .o_mty(o_mty2), .o_val(o_val2), .o_eop(o_eop2), .o_rdy(o_rdy2)
   );

   typedef struct {
      logic [7:0]  dat;
      logic        eop;
      logic        out;
      logic [31:0] xdat;
      logic [1:0]  xmty;
      logic        xeop;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      logic [1:0]  mty;
      logic        eop;
   } exp_t;

   vec_t vecs[12];
   exp_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] m, input logic e);
      exp_t x;
      x.dat = d; x.mty = m; x.eop = e;
      sb.push_back(x);
   endtask

   task automatic send(input logic [7:0] d, input logic e);
      int n = 0;
      i_dat = d; i_eop = e; i_val = 1'b1;
      @(negedge clk);
      while (!i_rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!i_rdy) begin
         total++; bad++;
         $display("FAIL send_timeout: got i_rdy=0 want 1 for word %0h", d);
      end
      @(posedge clk); #1;
      i_val = 1'b0; i_eop = 1'b0;
   endtask

   task automatic mon1();
      exp_t x;
      logic [31:0] m;
      logic er;
      forever begin
         @(negedge clk);
         if (reset) begin
            er = ~o_val | o_rdy;
            chk("i_rdy", i_rdy, er);
            if (o_val && o_rdy) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_out: got %0h want none", o_dat);
               end else begin
                  x = sb.pop_front();
                  m = 32'hFFFFFFFF;
`ifndef PS_WIDTH_MULTIPLIER_ZERO_FILL_EN
                  m = 32'hFFFFFFFF >> (8 * x.mty);
`endif
                  $display("out dat=%08h mty=%0d eop=%0d", o_dat, o_mty, o_eop);
                  chk("o_dat", o_dat & m, x.dat & m);
                  chk("o_mty", o_mty, x.mty);
                  chk("o_eop", o_eop, x.eop);
               end
            end
         end
      end
   endtask

   task automatic mon2();
      logic [11:0] xd, m;
      int w;
      logic er;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            er = ~o_val2 | o_rdy2;
            chk("i_rdy2", i_rdy2, er);
            if (o_val2) begin
               xd = '0; m = '0;
               for (int s = 0; s < 3; s++) begin
                  w = 3 * n_out2 + s + 1;
                  if (w <= 40) begin
                     xd[s*4 +: 4] = 4'(w);
                     m[s*4 +: 4]  = 4'hF;
                  end
               end
               $display("out2 #%0d dat=%03h mty=%0d eop=%0d", n_out2, o_dat2, o_mty2, o_eop2);
               chk("o_dat2", o_dat2 & m, xd);
               chk("o_mty2", o_mty2, (n_out2 == 13) ? 2 : 0);
               chk("o_eop2", o_eop2, (n_out2 == 13) ? 1 : 0);
               if (n_out2 > 0) chk("gap2", cyc - last_cyc, (n_out2 == 13) ? 1 : 3);
               last_cyc = cyc;
               n_out2++;
            end
         end
      end
   endtask

   initial begin
      vecs[0]  = '{8'h01, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[1]  = '{8'h02, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[2]  = '{8'h03, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[3]  = '{8'h04, 1'b0, 1'b1, 32'h04030201, 2'd0, 1'b0};
      vecs[4]  = '{8'h05, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[5]  = '{8'h06, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[6]  = '{8'h07, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[7]  = '{8'h08, 1'b1, 1'b1, 32'h08070605, 2'd0, 1'b1};
      vecs[8]  = '{8'hA1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[9]  = '{8'hA2, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
      vecs[10] = '{8'hA3, 1'b1, 1'b1, 32'h00A3A2A1, 2'd1, 1'b1};
      vecs[11] = '{8'h5A, 1'b1, 1'b1, 32'h0000005A, 2'd3, 1'b1};

      reset = 1'b0; i_dat = '0; i_val = 1'b0; i_eop = 1'b0; o_rdy = 1'b1;
      i_dat2 = '0; i_val2 = 1'b0; i_eop2 = 1'b0; o_rdy2 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_o_val", o_val, 0);
      chk("rst_o_eop", o_eop, 0);
      chk("rst_o_mty", o_mty, 0);
      chk("rst_o_dat", o_dat, 0);
      chk("rst_i_rdy", i_rdy, 1);
      @(posedge clk); #1;
      reset = 1'b1;

      fork
         mon1();
         mon2();
      join_none

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].out) push(vecs[i].xdat, vecs[i].xmty, vecs[i].xeop);
         send(vecs[i].dat, vecs[i].eop);
         if (vecs[i].out) begin
            @(negedge clk);
            chk("latency", o_val, 1);
            @(posedge clk); #1;
         end
      end

      // Backpressure: complete a word, hold o_rdy low, then release.
      o_rdy = 1'b0;
      push(32'hD4D3D2D1, 2'd0, 1'b1);
      send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0); send(8'hD4, 1'b1);
      i_dat = 8'hE1; i_val = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_i_rdy", i_rdy, 0);
         chk("hold_o_val", o_val, 1);
         chk("hold_o_dat", o_dat, 32'hD4D3D2D1);
         chk("hold_o_eop", o_eop, 1);
      end
      @(posedge clk); #1;
      o_rdy = 1'b1;
      send(8'hE1, 1'b0); send(8'hE2, 1'b0);
      push(32'h00E3E2E1, 2'd1, 1'b1);
      send(8'hE3, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Reset in the middle of a packet discards the partial word.
      send(8'h11, 1'b0); send(8'h22, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_o_val", o_val, 0);
      chk("mid_rst_o_dat", o_dat, 0);
      chk("mid_rst_o_eop", o_eop, 0);
      chk("mid_rst_o_mty", o_mty, 0);
      #1 reset = 1'b1;
      push(32'h44332211, 2'd0, 1'b1);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Continuous streaming on the COUNT=3 instance.
      for (int n = 0; n < 40; n++) begin
         i_val2 = 1'b1; i_dat2 = 4'(n + 1); i_eop2 = (n == 39);
         @(posedge clk); #1;
      end
      i_val2 = 1'b0; i_eop2 = 1'b0;
      repeat (5) @(negedge clk);
      chk("n_out2", n_out2, 14);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
